// File: rtl/svo_tmds_decode.sv
// svo_tmds_decode: TMDS receive-side channel decoder for one HDMI/DVI channel.
// Finds the 10-bit symbol boundary in an unaligned deserializer stream by hunting
// for control tokens, then decodes each aligned symbol into de/ctrl/pixel data.
//
// Ports:
//   clk     in   pixel clock, rising edge
//   resetn  in   asynchronous active-low reset
//   sin     in   raw 10-bit deserializer word, sin[0] earliest
//   locked  out  symbol alignment established
//   offset  out  current bit offset into the 20-bit window (0..9)
//   de      out  decoded data-enable
//   ctrl    out  decoded control bits, held while de=1
//   dout    out  decoded pixel data, 0 while de=0
`timescale 1ns/1ps
module svo_tmds_decode #(
    parameter int unsigned LOCK_TOKENS = 8,
    parameter int unsigned DWELL       = 2048
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] sin,
    output logic       locked,
    output logic [3:0] offset,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] dout
);

    localparam int unsigned DW = $clog2(DWELL + 1);
    localparam int unsigned RW = $clog2(LOCK_TOKENS + 1);

    localparam logic [DW-1:0] DwellLast = DW'(DWELL - 1);
    localparam logic [RW-1:0] RunMax    = RW'(LOCK_TOKENS);

    localparam logic [0:0] StSearch = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    // Returns {is_token, ctrl value}.
    function automatic logic [2:0] tok_decode(logic [9:0] sym);
        case (sym)
            10'b1101010100: return 3'b100;
            10'b0010101011: return 3'b101;
            10'b0101010100: return 3'b110;
            10'b1010101011: return 3'b111;
            default:        return 3'b000;
        endcase
    endfunction

    logic [9:0]    prev_q;
    logic [0:0]    state_q, state_d;
    logic [3:0]    offset_q, offset_d;
    logic [RW-1:0] run_q, run_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [9:0]    sym_q;
    logic          sym_vld_q;
    logic          de_q, de_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic [7:0]    dout_q, dout_d;

    logic [19:0]   win;
    logic [9:0]    aligned;
    logic [2:0]    a_tok;
    logic [2:0]    s_tok;
    logic [3:0]    offset_inc;
    logic [7:0]    d_raw;
    logic [7:0]    data_dec;

    // Older word sits in the low half so that bit 0 of the window is the earliest bit.
    assign win     = {sin, prev_q};
    assign aligned = win[{1'b0, offset_q} +: 10];
    assign a_tok   = tok_decode(aligned);
    assign s_tok   = tok_decode(sym_q);

    assign offset_inc = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

    // Alignment search / lock supervision.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        run_d    = run_q;
        dwell_d  = dwell_q;
        if (state_q == StSearch) begin
            if (!a_tok[2]) begin
                run_d = '0;
            end else if (run_q != RunMax) begin
                run_d = run_q + RW'(1);
            end
            // Reaching the token count wins over a slip on the same cycle.
            if (run_d == RunMax) begin
                state_d = StLocked;
                dwell_d = '0;
            end else if (dwell_q == DwellLast) begin
                offset_d = offset_inc;
                dwell_d  = '0;
                run_d    = '0;
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end else begin
            if (a_tok[2]) begin
                dwell_d = '0;
            end else if (dwell_q == DwellLast) begin
                state_d  = StSearch;
                offset_d = offset_inc;
                run_d    = '0;
                dwell_d  = '0;
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end
    end

    // TMDS data decode: undo the optional inversion, then the XOR/XNOR chain.
    always_comb begin
        d_raw       = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
        data_dec    = '0;
        data_dec[0] = d_raw[0];
        for (int i = 1; i < 8; i++) begin
            data_dec[i] = sym_q[8] ? (d_raw[i] ^ d_raw[i-1]) : ~(d_raw[i] ^ d_raw[i-1]);
        end
    end

    // Only symbols captured while locked are decoded; anything else gives idle outputs.
    always_comb begin
        de_d   = 1'b0;
        ctrl_d = 2'b00;
        dout_d = '0;
        if (state_q == StLocked && sym_vld_q) begin
            if (s_tok[2]) begin
                ctrl_d = s_tok[1:0];
            end else begin
                de_d   = 1'b1;
                ctrl_d = ctrl_q;
                dout_d = data_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q    <= '0;
            state_q   <= StSearch;
            offset_q  <= '0;
            run_q     <= '0;
            dwell_q   <= '0;
            sym_q     <= '0;
            sym_vld_q <= 1'b0;
            de_q      <= 1'b0;
            ctrl_q    <= 2'b00;
            dout_q    <= '0;
        end else begin
            prev_q    <= sin;
            state_q   <= state_d;
            offset_q  <= offset_d;
            run_q     <= run_d;
            dwell_q   <= dwell_d;
            sym_q     <= aligned;
            sym_vld_q <= (state_q == StLocked);
            de_q      <= de_d;
            ctrl_q    <= ctrl_d;
            dout_q    <= dout_d;
        end
    end

    assign locked = (state_q == StLocked);
    assign offset = offset_q;
    assign de     = de_q;
    assign ctrl   = ctrl_q;
    assign dout   = dout_q;

endmodule
